uart_mmio_responder: RTL and testbench
======================================

// Module: uart_mmio_responder
// PURPOSE
//  Device-side responder for the CPU's UART memory-mapped window (addr[31:28]=4'b1000).
//  Answers CPU loads/stores to control (offset 0x0), receive data (0x4) and transmit data (0x8).
//  Contains the serial 8N1 transmitter and receiver that drive/sample the board UART pins.
//  Sits beside data memory; the CPU's memory-stage read mux selects rdata for UART addresses.
// PARAMETERS
//  CLOCK_FREQ  50_000_000  system clock frequency, Hz
//  BAUD_RATE   115_200     serial bit rate; localparam CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division)
//  FIFO_DEPTH  4           receive FIFO entries, power of two; used only with UART_RX_FIFO_EN
// PORTS
//  clk      in   1   system clock, rising edge
//  rst      in   1   asynchronous, active-high reset
//  addr     in   32  CPU byte address for the current access
//  wdata    in   32  store data; only [7:0] used
//  we       in   1   store strobe, one cycle per store
//  re       in   1   load strobe, one cycle per load
//  rdata    out  32  load data, combinational from addr/state
//  serial_in   in   1   UART RX pin, asynchronous, idle high
//  serial_out  out  1   UART TX pin, idle high
// BEHAVIOUR
//  Decode: hit = addr[31:28]==4'b1000; offset = addr[3:0]. Non-hit or other offsets: rdata=0, stores ignored.
//  Control read (0x0): rdata = {29'b0, overrun, rx_valid, tx_ready}; no side effect except overrun clear (option).
//  Reset: serial_out=1, tx_ready=1, rx_valid=0, RX data=0, both FSMs IDLE. Applies mid-frame; frame abandoned.
//  TX FSM IDLE->START->DATA->STOP->IDLE:
//   - Store to 0x8 with tx_ready=1: latch wdata[7:0]; tx_ready=0 and serial_out=0 from next edge.
//   - Start bit, 8 data bits LSB first, stop bit 1; each held exactly CLKS_PER_BIT cycles (frame = 10*CLKS_PER_BIT).
//   - tx_ready=1 on the edge ending the stop bit; back-to-back store possible that cycle.
//   - Store to 0x8 while tx_ready=0: dropped, no effect on frame in progress.
//  RX FSM IDLE->START->DATA->STOP->IDLE:
//   - serial_in through 2-flop synchronizer; falling edge in IDLE enters START.
//   - Recheck at CLKS_PER_BIT/2: still 0 -> DATA, else glitch -> IDLE, nothing loaded.
//   - Sample 8 bits at mid-bit (every CLKS_PER_BIT), shift LSB first.
//   - Stop sample 1: load byte, rx_valid=1 next edge. Stop sample 0: framing error, byte discarded.
//  Receive read (0x4): rdata = {24'b0, rx_byte}; re at 0x4 clears rx_valid on next edge.
//   - re at 0x4 with rx_valid=0: returns stale byte, no state change.
//   - Pop and new-byte load in the same cycle: new byte wins, rx_valid stays 1.
//  TX and RX fully independent; simultaneous load/store to different offsets both honoured.
// CONFIGURATION
//  UART_RX_FIFO_EN defined: FIFO_DEPTH-entry RX FIFO; rx_valid = !empty; 0x4 returns head, re pops.
//   - Push when full: byte dropped, sticky overrun=1; cleared by re at 0x0 (next edge).
//   - Simultaneous push/pop when full: both occur, no overrun.
//  UART_RX_FIFO_EN undefined: single holding register; new byte overwrites unread byte, overrun bit reads 0.
// TESTING (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 -> CLKS_PER_BIT=10)
//  1 Reset: rst pulse -> serial_out=1; load 0x8000_0000 -> rdata=0x0000_0001.
//  2 Store 0x8000_0008 wdata=0xA5 -> tx_ready=0 next cycle; line 0, then 1,0,1,0,0,1,0,1, stop 1, 10 clk each; control=0x1 after 100 clks.
//  3 Drive RX frame 0x3C -> control=0x3; load 0x8000_0004 -> 0x0000_003C; next control read 0x1.
//  4 RX low 3 clks then high -> no byte; frame with stop=0 -> rx_valid stays 0.
//  5 Store 0x11 at 0x8 mid-frame of 0xA5 -> only 0xA5 on line; load 0x8000_000C / 0x9000_0004 -> rdata=0.
//  6 Five RX bytes 1..5, no reads: FIFO_EN -> reads 1,2,3,4, control bit2=1 then 0 after control read; no FIFO -> reads 5.
//  7 Assert rst mid-TX and mid-RX frame -> serial_out=1 at once, control=0x1, no byte delivered.

Source files
------------

// File: rtl/uart_mmio_if.sv
// uart_mmio_if: CPU-side load/store bus for the UART MMIO window.
//   addr   CPU byte address of the current access
//   wdata  store data (only [7:0] meaningful to the UART)
//   we     one-cycle store strobe
//   re     one-cycle load strobe
//   rdata  load data, combinational in the responder
// master: CPU side.  slave: responder side.
interface uart_mmio_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output we, output re, input rdata);
    modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder: device-side responder for the UART window (addr[31:28] == 4'b1000).
// Registers (addr[3:0]):
//   0x0 control  {29'b0, overrun, rx_valid, tx_ready}; a load clears overrun (FIFO build)
//   0x4 receive  {24'b0, rx_byte}; a load pops the received byte
//   0x8 transmit store wdata[7:0] starts an 8N1 frame when tx_ready
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   bus         uart_mmio_if.slave (addr, wdata, we, re in; rdata out)
//   serial_in   UART RX pin, asynchronous, idle high
//   serial_out  UART TX pin, idle high
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO with a sticky
// overrun flag; otherwise a single holding register that newer bytes overwrite.
module uart_mmio_responder #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    uart_mmio_if.slave   bus,
    input  logic         serial_in,
    output logic         serial_out
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HalfBit      = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CntW-1:0] BitEnd   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfEnd  = CntW'(HalfBit - 1);

    // ---------------- address decode ----------------
    logic hit, sel_ctrl, sel_rx, sel_tx;
    logic unused_bits;

    assign hit         = (bus.addr[31:28] == 4'b1000);
    assign sel_ctrl    = hit && (bus.addr[3:0] == 4'h0);
    assign sel_rx      = hit && (bus.addr[3:0] == 4'h4);
    assign sel_tx      = hit && (bus.addr[3:0] == 4'h8);
    assign unused_bits = ^{bus.wdata[31:8], bus.addr[27:4]};

    // ---------------- transmitter ----------------
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    tx_state_e         tx_state_q, tx_state_d;
    logic [CntW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              tx_line_q, tx_line_d;
    logic              tx_ready;

    assign tx_ready   = (tx_state_q == TxIdle);
    assign serial_out = tx_line_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                // Stores while busy are simply not looked at.
                if (bus.we && sel_tx) begin
                    tx_state_d = TxStart;
                    tx_shift_d = bus.wdata[7:0];
                    tx_line_d  = 1'b0;
                end
            end
            TxStart: begin
                if (tx_cnt_q == BitEnd) begin
                    tx_state_d = TxData;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                end
            end
            TxData: begin
                if (tx_cnt_q == BitEnd) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                    end
                end
            end
            TxStop: begin
                if (tx_cnt_q == BitEnd) begin
                    tx_state_d = TxIdle;
                    tx_cnt_d   = '0;
                end
            end
            default: begin
                tx_state_d = TxIdle;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // ---------------- receiver ----------------
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    logic [1:0]        rx_sync_q;
    logic              rx_prev_q;
    logic              rx_s;
    rx_state_e         rx_state_q, rx_state_d;
    logic [CntW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_load;

    assign rx_s = rx_sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_load    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s) begin
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                // Mid start bit: a line already back high was a glitch.
                if (rx_cnt_q == HalfEnd) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitEnd) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitEnd) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    rx_load    = rx_s;  // stop bit 0 is a framing error: discard
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], serial_in};
            rx_prev_q  <= rx_s;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // ---------------- receive storage ----------------
    logic       pop_req;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       overrun;

    assign pop_req = bus.re && sel_rx;

`ifdef UART_RX_FIFO_EN
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]  fifo_q [FIFO_DEPTH];
    logic [PtrW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, do_pop, do_push, ctrl_rd;
    logic        overrun_q, overrun_d;

    assign ctrl_rd = bus.re && sel_ctrl;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign do_pop  = pop_req && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign do_push = rx_load && (!full || do_pop);

    always_comb begin
        overrun_d = overrun_q;
        if (ctrl_rd) begin
            overrun_d = 1'b0;
        end
        if (rx_load && full && !do_pop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                fifo_q[wr_ptr_q[PtrW-1:0]] <= rx_shift_q;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            overrun_q <= overrun_d;
        end
    end

    assign rx_valid = !empty;
    assign rx_byte  = fifo_q[rd_ptr_q[PtrW-1:0]];
    assign overrun  = overrun_q;
`else
    localparam int unsigned unused_fifo_depth = FIFO_DEPTH;

    logic [7:0] rx_data_q;
    logic       rx_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (rx_load) begin
            // New byte wins over a same-cycle pop and overwrites an unread one.
            rx_data_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
        end else if (pop_req) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_byte  = rx_data_q;
    assign overrun  = 1'b0;
`endif

    // ---------------- load data ----------------
    always_comb begin
        bus.rdata = '0;
        if (sel_ctrl) begin
            bus.rdata = {29'b0, overrun, rx_valid, tx_ready};
        end else if (sel_rx) begin
            bus.rdata = {24'b0, rx_byte};
        end
    end

endmodule

// File: tb/tb_uart_mmio_responder.sv
module tb_uart_mmio_responder;

    localparam logic [31:0] ACtrl = 32'h8000_0000;
    localparam logic [31:0] ARx   = 32'h8000_0004;
    localparam logic [31:0] ATx   = 32'h8000_0008;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b1;
    logic serial_out;

    uart_mmio_if bus ();

    uart_mmio_responder #(
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .serial_in (serial_in),
        .serial_out(serial_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.re   = 1'b1;
        #1;
        d = bus.rdata;
        cyc();
        bus.re   = 1'b0;
        bus.addr = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        cyc();
        bus.we    = 1'b0;
        bus.addr  = '0;
    endtask

    // Issue a store of b, then follow the line for the whole frame. If drop_at >= 0 a second
    // store of 0x11 is attempted during that cycle of the frame.
    task automatic tx_frame(input logic [7:0] b, input int drop_at);
        logic [31:0] d;
        logic        exp_bit;
        int          idx;
        wr(ATx, {24'h0, b});
        for (int k = 0; k < 100; k++) begin
            idx = k / 10;
            if (idx == 0) exp_bit = 1'b0;
            else if (idx == 9) exp_bit = 1'b1;
            else exp_bit = b[idx-1];
            check("tx_line", {31'b0, serial_out}, {31'b0, exp_bit});
            if (k == drop_at) begin
                bus.addr  = ATx;
                bus.wdata = 32'h11;
                bus.we    = 1'b1;
                cyc();
                bus.we    = 1'b0;
            end else begin
                if (k == 0 || k == 99) begin
                    peek(ACtrl, d);
                    check("tx_busy_ctrl", d, 32'h0);
                end
                cyc();
            end
        end
        peek(ACtrl, d);
        check("tx_done_ctrl", d, 32'h1);
        check("tx_idle_line", {31'b0, serial_out}, 32'h1);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        serial_in = 1'b0;
        repeat (10) cyc();
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (10) cyc();
        end
        serial_in = stop;
        repeat (10) cyc();
        serial_in = 1'b1;
        repeat (5) cyc();
    endtask

    initial begin
        logic [31:0] d;

        vecs[0]  = '{1'b0, 32'h8000_0000, 32'h0,  32'h1};
        vecs[1]  = '{1'b0, 32'h8000_0004, 32'h0,  32'h0};
        vecs[2]  = '{1'b0, 32'h8000_0008, 32'h0,  32'h0};
        vecs[3]  = '{1'b0, 32'h8000_000C, 32'h0,  32'h0};
        vecs[4]  = '{1'b0, 32'h9000_0004, 32'h0,  32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,  32'h0};
        vecs[6]  = '{1'b0, 32'h8FFF_FFF0, 32'h0,  32'h1};
        vecs[7]  = '{1'b0, 32'h8000_0010, 32'h0,  32'h1};
        vecs[8]  = '{1'b1, 32'h9000_0008, 32'h77, 32'h0};
        vecs[9]  = '{1'b1, 32'h8000_000C, 32'h77, 32'h0};
        vecs[10] = '{1'b1, 32'h8000_0004, 32'h77, 32'h0};
        vecs[11] = '{1'b1, 32'h8000_0000, 32'h77, 32'h1};

        bus.addr  = '0;
        bus.wdata = '0;
        bus.we    = 1'b0;
        bus.re    = 1'b0;

        // Reset
        repeat (3) cyc();
        check("reset_line", {31'b0, serial_out}, 32'h1);
        rst = 1'b0;
        cyc();
        rd(ACtrl, d);
        check("reset_ctrl", d, 32'h1);

        // Decode table: loads/stores that must not start anything
        for (int i = 0; i < 12; i++) begin
            bus.addr  = vecs[i].addr;
            bus.wdata = vecs[i].wdata;
            bus.we    = vecs[i].we;
            bus.re    = !vecs[i].we;
            #1;
            check($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
            cyc();
            bus.we = 1'b0;
            bus.re = 1'b0;
            check($sformatf("vec%0d_line", i), {31'b0, serial_out}, 32'h1);
        end
        repeat (3) cyc();
        peek(ACtrl, d);
        check("vec_ctrl_after", d, 32'h1);

        // TX frame 0xA5, with a dropped store in the middle
        tx_frame(8'hA5, 35);
        for (int k = 0; k < 20; k++) begin
            if (serial_out !== 1'b1) check("tx_no_second_frame", {31'b0, serial_out}, 32'h1);
            cyc();
        end
        peek(ACtrl, d);
        check("tx_no_second_ctrl", d, 32'h1);

        // Back-to-back frame without a drop
        tx_frame(8'h3E, -1);

        // RX byte 0x3C
        rx_send(8'h3C, 1'b1);
        peek(ACtrl, d);
        check("rx_valid_ctrl", d, 32'h3);
        rd(ARx, d);
        check("rx_data", d, 32'h3C);
        peek(ACtrl, d);
        check("rx_popped_ctrl", d, 32'h1);
        rd(ARx, d);
        check("rx_stale", d, 32'h3C);

        // Start-bit glitch, then a framing error
        serial_in = 1'b0;
        repeat (3) cyc();
        serial_in = 1'b1;
        repeat (20) cyc();
        peek(ACtrl, d);
        check("rx_glitch_ctrl", d, 32'h1);
        rx_send(8'h55, 1'b0);
        repeat (10) cyc();
        peek(ACtrl, d);
        check("rx_frame_err_ctrl", d, 32'h1);
        rd(ARx, d);
        check("rx_frame_err_data", d, 32'h3C);

        // Five bytes with no reads
        for (int i = 1; i <= 5; i++) begin
            rx_send(i[7:0], 1'b1);
        end
`ifdef UART_RX_FIFO_EN
        rd(ACtrl, d);
        check("ovr_ctrl", d, 32'h7);
        peek(ACtrl, d);
        check("ovr_cleared_ctrl", d, 32'h3);
        for (int i = 1; i <= 4; i++) begin
            rd(ARx, d);
            check($sformatf("fifo_byte%0d", i), d, i);
        end
`else
        peek(ACtrl, d);
        check("ovw_ctrl", d, 32'h3);
        rd(ARx, d);
        check("ovw_byte", d, 32'h5);
`endif
        peek(ACtrl, d);
        check("drained_ctrl", d, 32'h1);

        // Reset in the middle of a TX frame and an RX frame
        wr(ATx, 32'hA5);
        serial_in = 1'b0;
        repeat (40) cyc();
        check("mid_tx_line", {31'b0, serial_out}, 32'h0);
        rst = 1'b1;
        #1;
        check("rst_line_now", {31'b0, serial_out}, 32'h1);
        peek(ACtrl, d);
        check("rst_ctrl_now", d, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        serial_in = 1'b1;
        for (int k = 0; k < 120; k++) begin
            if (serial_out !== 1'b1) check("post_rst_line", {31'b0, serial_out}, 32'h1);
            cyc();
        end
        peek(ACtrl, d);
        check("post_rst_ctrl", d, 32'h1);
        rd(ARx, d);
        check("post_rst_rx_data", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
